pattern_detector_prog: RTL and testbench
========================================

PATTERN_DETECTOR_PROG -- requirements
Module: pattern_detector_prog

Interface
REQ-001 Parameter MAX_LEN, default 8, maximum pattern length in bits (2..16).
REQ-002 Parameter LEN_W, default 4, width of cfg_len; SHALL satisfy 2**LEN_W > MAX_LEN.
REQ-003 Parameter CNT_W, default 8, width of match_count.
REQ-004 Parameter RST_PATTERN, default 8'b0000_1011, pattern loaded at reset.
REQ-005 Parameter RST_LEN, default 4, pattern length loaded at reset.
REQ-006 Parameter RST_OVERLAP, default 1, overlap mode loaded at reset.
REQ-007 clk  input  1  clock; all state changes on its rising edge.
REQ-008 reset  input  1  reset, asynchronous, active-high.
REQ-009 cfg_load  input  1  one-cycle strobe latching cfg_pattern, cfg_len, cfg_overlap.
REQ-010 cfg_pattern  input  MAX_LEN  pattern; bit [len-1] is the first bit expected, bit [0] the last.
REQ-011 cfg_len  input  LEN_W  active pattern length in bits.
REQ-012 cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-013 din_valid  input  1  qualifies din; din is ignored when low.
REQ-014 din  input  1  serial data bit.
REQ-015 cnt_clr  input  1  synchronous clear of match_count.
REQ-016 match  output  1  registered (Moore) one-cycle pulse per detected occurrence.
REQ-017 match_count  output  CNT_W  saturating count of detections.

Function
REQ-018 Block SHALL hold an active configuration register (pattern, len, overlap), a MAX_LEN-bit history shift register, and a fill counter (0..MAX_LEN) of valid bits since last clear.
REQ-019 On din_valid=1, history SHALL shift left with din entering bit [0]; fill SHALL increment, saturating at MAX_LEN.
REQ-020 A hit SHALL occur on an accepted bit when fill (including this bit) >= len and new history[len-1:0] == pattern[len-1:0].
REQ-021 match SHALL be asserted for exactly the one cycle following the clock edge that accepted the completing bit (latency 1), else 0.
REQ-022 Overlap mode: after a hit, history and fill SHALL be retained, so a suffix of a match can begin the next match.
REQ-023 Non-overlap mode: after a hit, fill SHALL be cleared to 0, so the next match needs len fresh bits.
REQ-024 Cycles with din_valid=0 SHALL leave history and fill unchanged and SHALL drive match=0.
REQ-025 cfg_load=1 SHALL latch configuration, clear history and fill, and force match=0 next cycle; match_count is unaffected.
REQ-026 cfg_load and din_valid in the same cycle: cfg_load SHALL win and the din bit SHALL be discarded.
REQ-027 cfg_len > MAX_LEN SHALL be clamped to MAX_LEN at load; cfg_len = 0 SHALL disable detection (match never asserts).
REQ-028 match_count SHALL increment by 1 on each hit and saturate at 2**CNT_W-1.
REQ-029 cnt_clr and a hit in the same cycle: match_count SHALL become 0; match SHALL still pulse.
REQ-030 Pattern bits above len-1 SHALL be ignored in comparison.

Reset
REQ-031 reset=1 SHALL asynchronously set pattern=RST_PATTERN, len=RST_LEN, overlap=RST_OVERLAP, history=0, fill=0, match=0, match_count=0.
REQ-032 Reset asserted mid-sequence SHALL discard partial progress; after release, detection SHALL require len fresh valid bits.
REQ-033 First bit accepted on the first rising edge after reset deassertion.

Verification
REQ-034 Defaults, din stream 1,0,1,1,0,1,1 all valid -> match pulses after bits 4 and 7; match_count=2.
REQ-035 Load pattern 8'b0000_0111, len 3, overlap=0; stream 1,1,1,1,1,1 -> match after bits 3 and 6 only; overlap=1 same stream -> match after bits 3,4,5,6.
REQ-036 Defaults, stream 1,0,1 then din_valid low 5 cycles then 1 -> single match 1 cycle after final bit; no match during gap.
REQ-037 cfg_len=12 with MAX_LEN=8, pattern 8'hA5 -> behaves as len 8; cfg_len=0 -> no match on any stream.
REQ-038 CNT_W=2, defaults, feed 5 occurrences of 1011 -> match_count saturates at 3; cnt_clr coincident with 6th hit -> count 0, match pulses.
REQ-039 Defaults, stream 1,0,1, assert reset, release, stream 1 -> no match; then 0,1,1,... requires full 1011 after release.

Source files
------------

// File: rtl/pattern_detector_prog_if.sv
// Configuration, serial-data and result signals of the programmable pattern detector.
interface pattern_detector_prog_if #(
   parameter int unsigned MAX_LEN = 8,
   parameter int unsigned LEN_W   = 4,
   parameter int unsigned CNT_W   = 8
);
   logic               cfg_load;
   logic [MAX_LEN-1:0] cfg_pattern;
   logic [LEN_W-1:0]   cfg_len;
   logic               cfg_overlap;
   logic               din_valid;
   logic               din;
   logic               cnt_clr;
   logic               match;
   logic [CNT_W-1:0]   match_count;

   modport master (
      output cfg_load, cfg_pattern, cfg_len, cfg_overlap, din_valid, din, cnt_clr,
      input  match, match_count
   );

   modport slave (
      input  cfg_load, cfg_pattern, cfg_len, cfg_overlap, din_valid, din, cnt_clr,
      output match, match_count
   );
endinterface

// File: rtl/pattern_detector_prog.sv
// Serial pattern detector with a runtime-loadable pattern/length/overlap mode,
// a one-cycle match pulse and a saturating match counter.
module pattern_detector_prog #(
   parameter int unsigned        MAX_LEN     = 8,
   parameter int unsigned        LEN_W       = 4,
   parameter int unsigned        CNT_W       = 8,
   parameter logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'(8'b0000_1011),
   parameter int unsigned        RST_LEN     = 4,
   parameter bit                 RST_OVERLAP = 1'b1
) (
   input logic                    clk,
   input logic                    reset,
   pattern_detector_prog_if.slave bus
);
   localparam logic [LEN_W-1:0] MAX_LEN_V = LEN_W'(MAX_LEN);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   logic [MAX_LEN-1:0] pat_q, pat_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic               ovl_q, ovl_d;
   logic [MAX_LEN-1:0] hist_q, hist_d;
   logic [LEN_W-1:0]   fill_q, fill_d;
   logic               match_q, match_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic [MAX_LEN-1:0] hist_shift;
   logic [MAX_LEN-1:0] len_mask;
   logic [LEN_W-1:0]   fill_inc;
   logic               hit;

   // Next-state: config load has priority over data; a hit only on an accepted bit.
   always_comb begin
      pat_d      = pat_q;
      len_d      = len_q;
      ovl_d      = ovl_q;
      hist_d     = hist_q;
      fill_d     = fill_q;
      cnt_d      = cnt_q;
      hit        = 1'b0;
      hist_shift = {hist_q[MAX_LEN-2:0], bus.din};
      fill_inc   = (fill_q == MAX_LEN_V) ? fill_q : fill_q + LEN_W'(1);
      for (int i = 0; i < MAX_LEN; i++) begin
         len_mask[i] = (LEN_W'(i) < len_q);
      end

      if (bus.cfg_load) begin
         pat_d  = bus.cfg_pattern;
         len_d  = (bus.cfg_len > MAX_LEN_V) ? MAX_LEN_V : bus.cfg_len;
         ovl_d  = bus.cfg_overlap;
         hist_d = '0;
         fill_d = '0;
      end else if (bus.din_valid) begin
         hit    = (len_q != '0) && (fill_inc >= len_q) &&
                  (((hist_shift ^ pat_q) & len_mask) == '0);
         hist_d = hist_shift;
         // Non-overlap restarts the fill so the next match needs len fresh bits.
         fill_d = (hit && !ovl_q) ? '0 : fill_inc;
      end

      if (bus.cnt_clr) begin
         cnt_d = '0;
      end else if (hit && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
      match_d = hit;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pat_q   <= RST_PATTERN;
         len_q   <= LEN_W'(RST_LEN);
         ovl_q   <= RST_OVERLAP;
         hist_q  <= '0;
         fill_q  <= '0;
         match_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         pat_q   <= pat_d;
         len_q   <= len_d;
         ovl_q   <= ovl_d;
         hist_q  <= hist_d;
         fill_q  <= fill_d;
         match_q <= match_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.match       = match_q;
   assign bus.match_count = cnt_q;
endmodule

// File: tb/tb_pattern_detector_prog.sv
// Bench for pattern_detector_prog: two instances (CNT_W=8 and CNT_W=2) share one stimulus
// stream and are checked every cycle against a queue-based model, plus pinned literal cases.
module tb_pattern_detector_prog;
   logic clk;
   logic reset;

   logic       d_load, d_ovl, d_valid, d_din, d_clr;
   logic [7:0] d_pat;
   logic [3:0] d_len;

   int total = 0;
   int bad   = 0;

   pattern_detector_prog_if #(.MAX_LEN(8), .LEN_W(4), .CNT_W(8)) bus8 ();
   pattern_detector_prog_if #(.MAX_LEN(8), .LEN_W(4), .CNT_W(2)) bus2 ();

   assign bus8.cfg_load = d_load;  assign bus2.cfg_load = d_load;
   assign bus8.cfg_pattern = d_pat; assign bus2.cfg_pattern = d_pat;
   assign bus8.cfg_len = d_len;    assign bus2.cfg_len = d_len;
   assign bus8.cfg_overlap = d_ovl; assign bus2.cfg_overlap = d_ovl;
   assign bus8.din_valid = d_valid; assign bus2.din_valid = d_valid;
   assign bus8.din = d_din;        assign bus2.din = d_din;
   assign bus8.cnt_clr = d_clr;    assign bus2.cnt_clr = d_clr;

   pattern_detector_prog #(.MAX_LEN(8), .LEN_W(4), .CNT_W(8)) dut8 (
      .clk(clk), .reset(reset), .bus(bus8.slave));
   pattern_detector_prog #(.MAX_LEN(8), .LEN_W(4), .CNT_W(2)) dut2 (
      .clk(clk), .reset(reset), .bus(bus2.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
      end
   endfunction

   // Reference model: list of bits accepted since the last clear.
   bit       q[$];
   bit [7:0] m_pat;
   int       m_len;
   bit       m_ovl;
   bit       exp_match;
   int       exp_cnt8, exp_cnt2;

   always @(posedge clk or posedge reset) begin : model
      bit hit;
      hit = 1'b0;
      if (reset) begin
         q.delete();
         m_pat = 8'b0000_1011; m_len = 4; m_ovl = 1'b1;
         exp_match = 1'b0; exp_cnt8 = 0; exp_cnt2 = 0;
      end else begin
         if (d_load) begin
            m_pat = d_pat;
            m_len = (int'(d_len) > 8) ? 8 : int'(d_len);
            m_ovl = d_ovl;
            q.delete();
         end else if (d_valid) begin
            q.push_back(d_din);
            if (q.size() > 8) void'(q.pop_front());
            if (m_len > 0 && q.size() >= m_len) begin
               hit = 1'b1;
               for (int k = 0; k < m_len; k++)
                  if (q[q.size() - 1 - k] != m_pat[k]) hit = 1'b0;
            end
            if (hit && !m_ovl) q.delete();
         end
         exp_match = hit;
         if (d_clr) begin
            exp_cnt8 = 0; exp_cnt2 = 0;
         end else if (hit) begin
            if (exp_cnt8 < 255) exp_cnt8++;
            if (exp_cnt2 < 3) exp_cnt2++;
         end
      end
   end

   always @(negedge clk) begin
      chk("match8", int'(bus8.match), int'(exp_match));
      chk("match2", int'(bus2.match), int'(exp_match));
      chk("count8", int'(bus8.match_count), exp_cnt8);
      chk("count2", int'(bus2.match_count), exp_cnt2);
   end

   task automatic step(input logic v, input logic d, input logic clr);
      d_load = 1'b0; d_valid = v; d_din = d; d_clr = clr;
      @(posedge clk); #1;
   endtask

   task automatic sendv(input string nm, input logic d, input logic e);
      step(1'b1, d, 1'b0);
      chk(nm, int'(bus8.match), int'(e));
   endtask

   // A valid '1' rides along with each load and must be discarded.
   task automatic load(input logic [7:0] p, input logic [3:0] l, input logic o);
      d_load = 1'b1; d_pat = p; d_len = l; d_ovl = o;
      d_valid = 1'b1; d_din = 1'b1; d_clr = 1'b0;
      @(posedge clk); #1;
      d_load = 1'b0; d_valid = 1'b0;
      chk("load_match", int'(bus8.match), 0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #2;
      chk("rst_match", int'(bus8.match), 0);
      chk("rst_count", int'(bus8.match_count), 0);
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   initial begin
      logic [6:0] bits7, exp7;
      logic [7:0] a5;
      reset = 1'b1;
      d_load = 1'b0; d_pat = '0; d_len = '0; d_ovl = 1'b0;
      d_valid = 1'b0; d_din = 1'b0; d_clr = 1'b0;
      @(posedge clk); #1;
      chk("reset_match", int'(bus8.match), 0);
      chk("reset_count", int'(bus8.match_count), 0);
      reset = 1'b0;

      // Defaults, 1011011 -> hits on bits 4 and 7.
      bits7 = 7'b1011011; exp7 = 7'b0001001;
      for (int i = 6; i >= 0; i--) sendv("dflt_stream", bits7[i], exp7[i]);
      chk("dflt_count", int'(bus8.match_count), 2);

      // 111 non-overlap then overlap over six ones.
      load(8'b0000_0111, 4'd3, 1'b0);
      for (int i = 1; i <= 6; i++) sendv("ones_novl", 1'b1, (i % 3) == 0);
      load(8'b0000_0111, 4'd3, 1'b1);
      for (int i = 1; i <= 6; i++) sendv("ones_ovl", 1'b1, i >= 3);

      // Gap of invalid cycles does not break or fire a match.
      load(8'b0000_1011, 4'd4, 1'b1);
      sendv("gap_a", 1'b1, 1'b0); sendv("gap_b", 1'b0, 1'b0); sendv("gap_c", 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b1, 1'b0);
         chk("gap_idle", int'(bus8.match), 0);
      end
      sendv("gap_end", 1'b1, 1'b1);

      // Length above MAX_LEN clamps to 8; length 0 never matches.
      a5 = 8'hA5;
      load(a5, 4'd12, 1'b1);
      for (int i = 7; i >= 0; i--) sendv("clamp_len", a5[i], i == 0);
      load(a5, 4'd0, 1'b1);
      for (int i = 0; i < 24; i++) sendv("len_zero", 1'($urandom), 1'b0);

      // Counter saturation and clear coincident with a hit.
      load(8'b0000_1011, 4'd4, 1'b1);
      step(1'b0, 1'b0, 1'b1);
      chk("clr_count", int'(bus8.match_count), 0);
      for (int n = 0; n < 5; n++) begin
         sendv("sat_a", 1'b1, 1'b0); sendv("sat_b", 1'b0, 1'b0);
         sendv("sat_c", 1'b1, 1'b0); sendv("sat_d", 1'b1, 1'b1);
      end
      chk("sat_count8", int'(bus8.match_count), 5);
      chk("sat_count2", int'(bus2.match_count), 3);
      sendv("clrhit_a", 1'b1, 1'b0); sendv("clrhit_b", 1'b0, 1'b0); sendv("clrhit_c", 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b1);
      chk("clrhit_match", int'(bus8.match), 1);
      chk("clrhit_count8", int'(bus8.match_count), 0);
      chk("clrhit_count2", int'(bus2.match_count), 0);

      // Reset mid-pattern discards partial progress.
      sendv("mid_a", 1'b1, 1'b0); sendv("mid_b", 1'b0, 1'b0); sendv("mid_c", 1'b1, 1'b0);
      d_valid = 1'b0;
      do_reset();
      sendv("post_a", 1'b1, 1'b0); sendv("post_b", 1'b0, 1'b0);
      sendv("post_c", 1'b1, 1'b0); sendv("post_d", 1'b1, 1'b1);

      // Randomized traffic checked by the per-cycle model compare.
      for (int c = 0; c < 3000; c++) begin
         int r;
         r = int'($urandom_range(0, 99));
         if (r < 3) begin
            load(8'($urandom), ($urandom_range(0, 99) < 80) ? 4'($urandom_range(1, 4))
                                                          : 4'($urandom_range(0, 15)),
                 1'($urandom));
         end else if (r < 4) begin
            do_reset();
         end else begin
            step(($urandom_range(0, 3) != 0), 1'($urandom), r >= 97);
         end
      end
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
